// File: rtl/matrix_row_sequencer.sv
// matrix_row_sequencer: operand stage of the matrix ALU. It reads matrix A, and
// matrix B for add/sub, one row at a time. It masks lanes beyond the matrix size,
// builds operand 2, and presents one 40-bit row pair per valid/ready transfer.
// Latency per row with out_ready held high: 4 cycles for add/sub, 3 cycles for
// multMR/opp. done follows the last handshake by 1 cycle. Illegal commands
// finish 1 cycle after start.
// Backpressure: while out_ready is low, PRES holds the row pair, row_idx and alu_op.
// Optional feature macro: SEQ_OVF_STICKY_EN enables the accumulated ovf_sticky flag.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   start/op/size/scalar - command interface, sampled only in IDLE
//   mem_rd/mem_addr/mem_rdata - matrix memory read port (data valid 1 cycle after mem_rd)
//   alu_op/r1_row/r2_row/row_idx/out_valid/out_ready/alu_ovf - ALU row-pair interface
//   busy/done/err/ovf_sticky - command status
module matrix_row_sequencer #(
  parameter int ADDR_W = 4,
  parameter int A_BASE = 0,
  parameter int B_BASE = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [2:0]        size,
  input  logic [7:0]        scalar,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [39:0]       mem_rdata,
  output logic [2:0]        alu_op,
  output logic [39:0]       r1_row,
  output logic [39:0]       r2_row,
  output logic [2:0]        row_idx,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              alu_ovf,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ovf_sticky
);

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_MULTMR = 3'b011;
  localparam logic [2:0] OP_OPP    = 3'b110;

  localparam logic [ADDR_W-1:0] A_BASE_L = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] B_BASE_L = ADDR_W'(B_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RDA,
    S_RDB,
    S_CAPB,
    S_PRES,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  size_q;
  logic [7:0]  scalar_q;
  logic        err_q;
  logic        legal_cmd;
  logic        needs_b;
  logic        last_row;
  logic        handshake;
  logic [39:0] lane_mask;

  assign legal_cmd = ((op == OP_ADD) || (op == OP_SUB) || (op == OP_MULTMR) || (op == OP_OPP))
                     && (size >= 3'd1) && (size <= 3'd5);
  assign needs_b   = (alu_op == OP_ADD) || (alu_op == OP_SUB);
  assign last_row  = (row_idx == (size_q - 3'd1));
  assign handshake = (state == S_PRES) && out_ready;

  // One byte lane is enabled for each active matrix column.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < 5; k++) begin
      if (k < int'(size_q)) lane_mask[8*k +: 8] = 8'hFF;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = legal_cmd ? S_RDA : S_DONE;
      S_RDA:  state_nxt = S_RDB;
      S_RDB:  state_nxt = needs_b ? S_CAPB : S_PRES;
      S_CAPB: state_nxt = S_PRES;
      S_PRES: if (out_ready) state_nxt = last_row ? S_DONE : S_RDA;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    mem_rd    = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_RDA: begin
        busy     = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = A_BASE_L + ADDR_W'(row_idx);
      end
      S_RDB: begin
        busy = 1'b1;
        if (needs_b) begin
          mem_rd   = 1'b1;
          mem_addr = B_BASE_L + ADDR_W'(row_idx);
        end
      end
      S_CAPB: busy = 1'b1;
      S_PRES: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  // Command latch and operand datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op   <= '0;
      size_q   <= '0;
      scalar_q <= '0;
      row_idx  <= '0;
      r1_row   <= '0;
      r2_row   <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal_cmd) begin
              alu_op   <= op;
              size_q   <= size;
              scalar_q <= scalar;
              row_idx  <= '0;
              err_q    <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_RDB: begin
          // The A row read in RDA is on mem_rdata now.
          r1_row <= mem_rdata & lane_mask;
          if (alu_op == OP_MULTMR) r2_row <= {5{scalar_q}} & lane_mask;
          else if (!needs_b)       r2_row <= '0;
        end
        S_CAPB: r2_row <= mem_rdata & lane_mask;
        S_PRES: if (out_ready && !last_row) row_idx <= row_idx + 3'd1;
        default: ;
      endcase
    end
  end

`ifdef SEQ_OVF_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst)                                        ovf_sticky <= 1'b0;
    else if ((state == S_IDLE) && start && legal_cmd) ovf_sticky <= 1'b0;
    else if (handshake && alu_ovf)                  ovf_sticky <= 1'b1;
  end
`else
  logic unused_ovf;
  assign unused_ovf = alu_ovf ^ handshake;
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_row_sequencer.sv
module tb_matrix_row_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  size;
  logic [7:0]  scalar;
  logic        mem_rd;
  logic [3:0]  mem_addr;
  logic [39:0] mem_rdata;
  logic [2:0]  alu_op;
  logic [39:0] r1_row;
  logic [39:0] r2_row;
  logic [2:0]  row_idx;
  logic        out_valid;
  logic        out_ready;
  logic        alu_ovf;
  logic        busy;
  logic        done;
  logic        err;
  logic        ovf_sticky;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;
  int rdb_cnt = 0;
  logic [39:0] mem [16];

  always #5 clk = ~clk;

  matrix_row_sequencer #(.ADDR_W(4), .A_BASE(0), .B_BASE(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .size(size), .scalar(scalar),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .alu_op(alu_op), .r1_row(r1_row), .r2_row(r2_row), .row_idx(row_idx),
    .out_valid(out_valid), .out_ready(out_ready), .alu_ovf(alu_ovf),
    .busy(busy), .done(done), .err(err), .ovf_sticky(ovf_sticky)
  );

  // Memory model: one-cycle read latency, plus read counters.
  always @(posedge clk) begin
    if (mem_rd) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt++;
      if (mem_addr >= 4'd5) rdb_cnt++;
    end
  end

  // Issue a one-cycle start; returns at the negedge of the first command cycle.
  task automatic cmd(input logic [2:0] o, input logic [2:0] s, input logic [7:0] sc);
    @(negedge clk);
    start = 1'b1; op = o; size = s; scalar = sc;
    @(negedge clk);
    start = 1'b0; op = 3'b111; size = 3'd0; scalar = 8'h00;
  endtask

  task automatic load_add_mem();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 40'h0000030201; mem[1] = 40'hAABB0C0B0A; mem[2] = 40'h1122334455;
    mem[5] = 40'h0000010101; mem[6] = 40'hFFFF020202; mem[7] = 40'h9900030303;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; size = '0; scalar = '0;
    out_ready = 1'b0; alu_ovf = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_rd, mem_addr, alu_op, r1_row, r2_row, row_idx, out_valid, busy, done, err, ovf_sticky} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got mem_rd=%b addr=%h busy=%b done=%b out_valid=%b r1=%h, required all 0",
               mem_rd, mem_addr, busy, done, out_valid, r1_row);
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [39:0] exp_r1 [3];
    logic [39:0] exp_r2 [3];
    int hs;
    int done_cyc;
    exp_r1[0] = 40'h0000030201; exp_r1[1] = 40'h00000C0B0A; exp_r1[2] = 40'h0000334455;
    exp_r2[0] = 40'h0000010101; exp_r2[1] = 40'h0000020202; exp_r2[2] = 40'h0000030303;
    load_add_mem();
    out_ready = 1'b1; rd_cnt = 0; rdb_cnt = 0; hs = 0; done_cyc = 0;
    cmd(3'b000, 3'd3, 8'h00);
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (out_valid) begin
        n_tests++;
        if (hs > 2) begin
          n_fail++; $display("FAIL add_extra_row: got row_idx=%0d, required no row beyond 2", row_idx);
        end else if ({row_idx, r1_row, r2_row, alu_op, 32'(cyc)} !== {3'(hs), exp_r1[hs], exp_r2[hs], 3'b000, 32'(4*(hs+1))}) begin
          n_fail++;
          $display("FAIL add_row%0d: got idx=%0d r1=%h r2=%h op=%b cyc=%0d, required idx=%0d r1=%h r2=%h op=000 cyc=%0d",
                   hs, row_idx, r1_row, r2_row, alu_op, cyc, hs, exp_r1[hs], exp_r2[hs], 4*(hs+1));
        end
        hs++;
      end
      if (done) begin
        done_cyc = cyc;
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL add_err: got %b, required 0", err); end
      end
    end
    n_tests++;
    if (done_cyc != 13) begin n_fail++; $display("FAIL add_done_cycle: got %0d, required 13", done_cyc); end
    n_tests++;
    if (rd_cnt != 6 || rdb_cnt != 3) begin
      n_fail++; $display("FAIL add_reads: got %0d total %0d B, required 6 total 3 B", rd_cnt, rdb_cnt);
    end
  endtask

  task automatic test_multmr();
    int hs;
    int done_cyc;
    for (int i = 0; i < 16; i++) mem[i] = 40'h1234567890;
    mem[0] = 40'hFFFFFFFFFF; mem[1] = 40'hFFFFFFFFFF;
    out_ready = 1'b1; rd_cnt = 0; rdb_cnt = 0; hs = 0; done_cyc = 0;
    cmd(3'b011, 3'd2, 8'h05);
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      // An illegal start while busy must be ignored.
      if (cyc == 2) begin start = 1'b1; op = 3'b010; size = 3'd0; end
      if (cyc == 3) start = 1'b0;
      if (out_valid) begin
        n_tests++;
        if ({row_idx, r1_row, r2_row, alu_op, 32'(cyc)} !== {3'(hs), 40'h000000FFFF, 40'h0000000505, 3'b011, 32'(3*(hs+1))}) begin
          n_fail++;
          $display("FAIL multmr_row%0d: got idx=%0d r1=%h r2=%h op=%b cyc=%0d, required idx=%0d r1=000000ffff r2=0000000505 op=011 cyc=%0d",
                   hs, row_idx, r1_row, r2_row, alu_op, cyc, hs, 3*(hs+1));
        end
        hs++;
      end
      if (done) begin
        done_cyc = cyc;
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL multmr_err: got %b, required 0", err); end
      end
    end
    n_tests++;
    if (done_cyc != 7 || hs != 2) begin
      n_fail++; $display("FAIL multmr_done: got cycle %0d rows %0d, required cycle 7 rows 2", done_cyc, hs);
    end
    n_tests++;
    if (rd_cnt != 2 || rdb_cnt != 0) begin
      n_fail++; $display("FAIL multmr_reads: got %0d total %0d B, required 2 total 0 B", rd_cnt, rdb_cnt);
    end
  endtask

  task automatic test_opp_stall();
    int hs_cyc [5];
    int hs;
    int done_cyc;
    hs_cyc[0] = 3; hs_cyc[1] = 10; hs_cyc[2] = 13; hs_cyc[3] = 16; hs_cyc[4] = 19;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 40'h0102030405; mem[1] = 40'h1112131415; mem[2] = 40'h2122232425;
    mem[3] = 40'h3132333435; mem[4] = 40'h4142434445;
    out_ready = 1'b1; rd_cnt = 0; rdb_cnt = 0; hs = 0; done_cyc = 0;
    cmd(3'b110, 3'd5, 8'h77);
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 6)  out_ready = 1'b0;
      if (cyc == 10) out_ready = 1'b1;
      if (cyc >= 6 && cyc <= 9) begin
        n_tests++;
        if ({out_valid, row_idx, r1_row, r2_row, alu_op} !== {1'b1, 3'd1, 40'h1112131415, 40'h0, 3'b110}) begin
          n_fail++;
          $display("FAIL opp_stall_c%0d: got valid=%b idx=%0d r1=%h r2=%h, required valid=1 idx=1 r1=1112131415 r2=0",
                   cyc, out_valid, row_idx, r1_row, r2_row);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (hs > 4) begin
          n_fail++; $display("FAIL opp_extra_row: got row_idx=%0d, required no row beyond 4", row_idx);
        end else if ({row_idx, r1_row, r2_row, 32'(cyc)} !== {3'(hs), mem[hs], 40'h0, 32'(hs_cyc[hs])}) begin
          n_fail++;
          $display("FAIL opp_row%0d: got idx=%0d r1=%h r2=%h cyc=%0d, required idx=%0d r1=%h r2=0 cyc=%0d",
                   hs, row_idx, r1_row, r2_row, cyc, hs, mem[hs], hs_cyc[hs]);
        end
        hs++;
      end
      if (done) done_cyc = cyc;
    end
    n_tests++;
    if (done_cyc != 20 || hs != 5) begin
      n_fail++; $display("FAIL opp_done: got cycle %0d rows %0d, required cycle 20 rows 5", done_cyc, hs);
    end
    n_tests++;
    if (rd_cnt != 5 || rdb_cnt != 0) begin
      n_fail++; $display("FAIL opp_reads: got %0d total %0d B, required 5 total 0 B", rd_cnt, rdb_cnt);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] ops [2];
    logic [2:0] sizes [2];
    ops[0] = 3'b010; sizes[0] = 3'd3;
    ops[1] = 3'b000; sizes[1] = 3'd0;
    for (int t = 0; t < 2; t++) begin
      rd_cnt = 0;
      cmd(ops[t], sizes[t], 8'h00);
      n_tests++;
      if ({done, err, busy} !== 3'b110) begin
        n_fail++; $display("FAIL illegal%0d_pulse: got done=%b err=%b busy=%b, required 1 1 0", t, done, err, busy);
      end
      @(negedge clk);
      n_tests++;
      if ({done, err, busy} !== 3'b000) begin
        n_fail++; $display("FAIL illegal%0d_after: got done=%b err=%b busy=%b, required 0 0 0", t, done, err, busy);
      end
      n_tests++;
      if (rd_cnt != 0) begin n_fail++; $display("FAIL illegal%0d_reads: got %0d, required 0", t, rd_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    int done_seen;
    int done_cyc;
    load_add_mem();
    out_ready = 1'b1;
    cmd(3'b000, 3'd3, 8'h00);
    repeat (10) @(negedge clk);  // now in cycle 11: CAPB of row 2
    n_tests++;
    if ({busy, mem_rd, out_valid, row_idx} !== {1'b1, 1'b0, 1'b0, 3'd2}) begin
      n_fail++; $display("FAIL rstmid_capb: got busy=%b mem_rd=%b valid=%b idx=%0d, required 1 0 0 2",
                         busy, mem_rd, out_valid, row_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({mem_rd, mem_addr, alu_op, r1_row, r2_row, row_idx, out_valid, busy, done, err, ovf_sticky} !== 96'h0) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%b done=%b r1=%h r2=%h idx=%0d, required all 0",
                         busy, done, r1_row, r2_row, row_idx);
    end
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_tests++;
    if (done_seen != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses, required 0", done_seen); end
    mem[0] = 40'hABCDEF1234;
    done_cyc = 0;
    cmd(3'b110, 3'd1, 8'h00);
    for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (out_valid) begin
        n_tests++;
        if ({r1_row, r2_row, 32'(cyc)} !== {40'h0000000034, 40'h0, 32'd3}) begin
          n_fail++; $display("FAIL rstmid_rerun_row: got r1=%h r2=%h cyc=%0d, required r1=0000000034 r2=0 cyc=3",
                             r1_row, r2_row, cyc);
        end
      end
      if (done) done_cyc = cyc;
    end
    n_tests++;
    if (done_cyc != 4) begin n_fail++; $display("FAIL rstmid_rerun_done: got %0d, required 4", done_cyc); end
  endtask

  task automatic test_ovf_sticky();
    logic [39:0] exp_r1 [4];
    logic [39:0] exp_r2 [4];
    logic sticky_exp;
    int hs;
    int done_cyc;
`ifdef SEQ_OVF_STICKY_EN
    sticky_exp = 1'b1;
`else
    sticky_exp = 1'b0;
`endif
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 40'hEE10101010; mem[1] = 40'hEE20202020; mem[2] = 40'hEE30303030; mem[3] = 40'hEE40404040;
    mem[5] = 40'hDD01010101; mem[6] = 40'hDD02020202; mem[7] = 40'hDD03030303; mem[8] = 40'hDD04040404;
    exp_r1[0] = 40'h0010101010; exp_r1[1] = 40'h0020202020; exp_r1[2] = 40'h0030303030; exp_r1[3] = 40'h0040404040;
    exp_r2[0] = 40'h0001010101; exp_r2[1] = 40'h0002020202; exp_r2[2] = 40'h0003030303; exp_r2[3] = 40'h0004040404;
    out_ready = 1'b1; hs = 0; done_cyc = 0;
    cmd(3'b001, 3'd4, 8'h00);
    for (int cyc = 1; cyc <= 40 && done_cyc == 0; cyc++) begin
      if (cyc > 1) @(negedge clk);
      alu_ovf = (cyc == 8);
      if (cyc == 8) begin
        n_tests++;
        if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %b, required 0", ovf_sticky); end
      end
      if (cyc == 9 || cyc == 17) begin
        n_tests++;
        if (ovf_sticky !== sticky_exp) begin
          n_fail++; $display("FAIL ovf_c%0d: got %b, required %b", cyc, ovf_sticky, sticky_exp);
        end
      end
      if (out_valid) begin
        n_tests++;
        if (hs > 3) begin
          n_fail++; $display("FAIL sub_extra_row: got row_idx=%0d, required no row beyond 3", row_idx);
        end else if ({row_idx, r1_row, r2_row, alu_op, 32'(cyc)} !== {3'(hs), exp_r1[hs], exp_r2[hs], 3'b001, 32'(4*(hs+1))}) begin
          n_fail++;
          $display("FAIL sub_row%0d: got idx=%0d r1=%h r2=%h op=%b cyc=%0d, required idx=%0d r1=%h r2=%h op=001 cyc=%0d",
                   hs, row_idx, r1_row, r2_row, alu_op, cyc, hs, exp_r1[hs], exp_r2[hs], 4*(hs+1));
        end
        hs++;
      end
      if (done) done_cyc = cyc;
    end
    alu_ovf = 1'b0;
    n_tests++;
    if (done_cyc != 17) begin n_fail++; $display("FAIL sub_done_cycle: got %0d, required 17", done_cyc); end
    @(negedge clk);
    n_tests++;
    if (ovf_sticky !== sticky_exp) begin n_fail++; $display("FAIL ovf_hold: got %b, required %b", ovf_sticky, sticky_exp); end
    cmd(3'b110, 3'd1, 8'h00);
    n_tests++;
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b, required 0", ovf_sticky); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_multmr();
    test_opp_stall();
    test_illegal();
    test_reset_mid();
    test_ovf_sticky();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
